// File: rtl/leaf_stream_input_buffer_pkg.sv
// Shared leaf interface constants: packet field layout and BFT port numbering,
// common to leaf_stream_input_buffer and Extract_Control.
package leaf_interface_pkg;

  localparam int FIRST_IN_PORT       = 2;
  localparam int INPUT_PORT_MAX_NUM  = 8;
  localparam int OUTPUT_PORT_MIN_NUM = 9;

  // Packet layout, MSB first: {vld, leaf, port, payload}
  function automatic int payload_bits(input int packet_bits, input int leaf_bits,
                                      input int port_bits);
    return packet_bits - 1 - leaf_bits - port_bits;
  endfunction

  function automatic int vld_pos(input int packet_bits);
    return packet_bits - 1;
  endfunction

  function automatic int port_lsb(input int packet_bits, input int leaf_bits,
                                  input int port_bits);
    return payload_bits(packet_bits, leaf_bits, port_bits);
  endfunction

  function automatic int leaf_lsb(input int packet_bits, input int leaf_bits,
                                  input int port_bits);
    return payload_bits(packet_bits, leaf_bits, port_bits) + port_bits;
  endfunction

endpackage

// File: rtl/leaf_stream_input_buffer_if.sv
// Stream-in / per-port valid-ready bundle of leaf_stream_input_buffer.
// master = the buffer, slave = the leaf user logic plus the upstream driver.
interface leaf_stream_input_buffer_if
  import leaf_interface_pkg::*;
#(
  parameter int PACKET_BITS   = 97,
  parameter int NUM_LEAF_BITS = 6,
  parameter int NUM_PORT_BITS = 4,
  parameter int NUM_IN_PORTS  = 7
);
  localparam int PAYLOAD_BITS = payload_bits(PACKET_BITS, NUM_LEAF_BITS, NUM_PORT_BITS);

  logic [PACKET_BITS-1:0]               stream_in;
  logic [NUM_IN_PORTS*PAYLOAD_BITS-1:0] dout;
  logic [NUM_IN_PORTS-1:0]              dout_valid;
  logic [NUM_IN_PORTS-1:0]              dout_ready;
  logic [NUM_IN_PORTS-1:0]              overflow;
  logic [NUM_IN_PORTS*8-1:0]            drop_count;

  modport master (
    input  stream_in, dout_ready,
    output dout, dout_valid, overflow, drop_count
  );

  modport slave (
    output stream_in, dout_ready,
    input  dout, dout_valid, overflow, drop_count
  );
endinterface

// File: rtl/leaf_stream_input_buffer_port_fifo.sv
// leaf_port_fifo: first-word-fall-through FIFO with wrap-bit pointers.
// A push while full is accepted only when the head is popped on the same edge.
module leaf_port_fifo #(
  parameter int WIDTH = 86,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic             full,
  output logic             valid,
  output logic [WIDTH-1:0] dout
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_pop;
  logic             do_push;

  assign valid   = (wr_ptr != rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop & valid;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // When full, the written slot is the head being popped on this same edge
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end
endmodule

// File: rtl/leaf_stream_input_buffer.sv
// Demultiplexes BFT stream packets for input ports 2..NUM_IN_PORTS+1 into per-port
// FWFT FIFOs with sticky overflow flags. Optional drop counters: LEAF_DROP_COUNT_EN.
module leaf_stream_input_buffer
  import leaf_interface_pkg::*;
#(
  parameter int PACKET_BITS   = 97,
  parameter int NUM_LEAF_BITS = 6,
  parameter int NUM_PORT_BITS = 4,
  parameter int NUM_IN_PORTS  = 7,
  parameter int FIFO_DEPTH    = 4
) (
  input logic                        clk,
  input logic                        reset_n,
  leaf_stream_input_buffer_if.master bus
);
  localparam int PAYLOAD_BITS = payload_bits(PACKET_BITS, NUM_LEAF_BITS, NUM_PORT_BITS);
  localparam int VLD_POS      = vld_pos(PACKET_BITS);
  localparam int PORT_LSB     = port_lsb(PACKET_BITS, NUM_LEAF_BITS, NUM_PORT_BITS);
  localparam int LEAF_LSB     = leaf_lsb(PACKET_BITS, NUM_LEAF_BITS, NUM_PORT_BITS);

  logic                     vld_p0;
  logic [NUM_PORT_BITS-1:0] port_p0;
  logic [PAYLOAD_BITS-1:0]  payload_p0;
  logic [NUM_LEAF_BITS-1:0] leaf_unused;
  logic [NUM_IN_PORTS-1:0]  push_req;
  logic [NUM_IN_PORTS-1:0]  full;
  logic [NUM_IN_PORTS-1:0]  head_vld;
  logic [NUM_IN_PORTS-1:0]  drop;
  logic [NUM_IN_PORTS-1:0]  overflow_q;
  logic [PAYLOAD_BITS-1:0]  head_data [NUM_IN_PORTS];

  // Stage p0: field decode of the already-registered upstream packet
  assign vld_p0      = bus.stream_in[VLD_POS];
  assign port_p0     = bus.stream_in[PORT_LSB +: NUM_PORT_BITS];
  assign payload_p0  = bus.stream_in[PAYLOAD_BITS-1:0];
  assign leaf_unused = bus.stream_in[LEAF_LSB +: NUM_LEAF_BITS];

  for (genvar i = 0; i < NUM_IN_PORTS; i++) begin : g_port
    assign push_req[i] = vld_p0 && (port_p0 == NUM_PORT_BITS'(i + FIRST_IN_PORT));
    assign drop[i]     = push_req[i] & full[i] & ~(bus.dout_ready[i] & head_vld[i]);

    leaf_port_fifo #(
      .WIDTH (PAYLOAD_BITS),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (push_req[i]),
      .din     (payload_p0),
      .pop     (bus.dout_ready[i]),
      .full    (full[i]),
      .valid   (head_vld[i]),
      .dout    (head_data[i])
    );

    assign bus.dout[i*PAYLOAD_BITS +: PAYLOAD_BITS] = head_data[i];
  end

  assign bus.dout_valid = head_vld;
  assign bus.overflow   = overflow_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) overflow_q <= '0;
    else          overflow_q <= overflow_q | drop;
  end

`ifdef LEAF_DROP_COUNT_EN
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic [7:0] drop_cnt [NUM_IN_PORTS];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_IN_PORTS; i++) drop_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_IN_PORTS; i++)
        if (drop[i]) drop_cnt[i] <= sat_inc8(drop_cnt[i]);
    end
  end

  for (genvar i = 0; i < NUM_IN_PORTS; i++) begin : g_cnt
    assign bus.drop_count[i*8 +: 8] = drop_cnt[i];
  end
`else
  assign bus.drop_count = '0;
`endif
endmodule

// File: tb/tb_leaf_stream_input_buffer.sv
// Bench for leaf_stream_input_buffer: directed scenarios then random traffic,
// compared against a per-port queue model. Honours LEAF_DROP_COUNT_EN.
module tb_leaf_stream_input_buffer;
  localparam int PB    = 97;
  localparam int PW    = 86;
  localparam int NP    = 7;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset_n;
  int   checks   = 0;
  int   failures = 0;

  leaf_stream_input_buffer_if #(
    .PACKET_BITS(PB), .NUM_LEAF_BITS(6), .NUM_PORT_BITS(4), .NUM_IN_PORTS(NP)
  ) bus ();

  leaf_stream_input_buffer #(
    .PACKET_BITS(PB), .NUM_LEAF_BITS(6), .NUM_PORT_BITS(4),
    .NUM_IN_PORTS(NP), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Reference model: one payload queue per input port
  logic [PW-1:0] mq [NP][$];
  logic [NP-1:0] m_ovf;
  int            m_dc [NP];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [PB-1:0] mk(input logic vld, input int port, input logic [PW-1:0] pl);
    logic [5:0] leaf;
    leaf = 6'($urandom_range(0, 63));
    return {vld, leaf, 4'(port), pl};
  endfunction

  function automatic logic [PW-1:0] rnd_pl();
    return PW'({$urandom(), $urandom(), $urandom()});
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NP; i++) begin
      mq[i].delete();
      m_dc[i] = 0;
    end
    m_ovf = '0;
  endtask

  task automatic model_step(input logic [PB-1:0] pkt, input logic [NP-1:0] rdy);
    int p;
    p = int'(pkt[89:86]);
    for (int i = 0; i < NP; i++)
      if (rdy[i] && mq[i].size() > 0) void'(mq[i].pop_front());
    if (pkt[96] && p >= 2 && p <= NP + 1) begin
      if (mq[p-2].size() < DEPTH) mq[p-2].push_back(pkt[PW-1:0]);
      else begin
        m_ovf[p-2] = 1'b1;
`ifdef LEAF_DROP_COUNT_EN
        if (m_dc[p-2] < 255) m_dc[p-2]++;
`endif
      end
    end
  endtask

  task automatic check_all(input string tag);
    logic [NP-1:0]   ev;
    logic [8*NP-1:0] edc;
    for (int i = 0; i < NP; i++) begin
      ev[i]          = (mq[i].size() > 0);
      edc[i*8 +: 8]  = 8'(m_dc[i]);
    end
    chk({tag, ":valid"}, 128'(bus.dout_valid), 128'(ev));
    chk({tag, ":ovf"},   128'(bus.overflow),   128'(m_ovf));
    chk({tag, ":dcnt"},  128'(bus.drop_count), 128'(edc));
    for (int i = 0; i < NP; i++)
      if (ev[i]) chk($sformatf("%s:dout%0d", tag, i), 128'(bus.dout[i*PW +: PW]), 128'(mq[i][0]));
  endtask

  task automatic cycle(input string tag, input logic [PB-1:0] pkt, input logic [NP-1:0] rdy);
    bus.stream_in  = pkt;
    bus.dout_ready = rdy;
    @(posedge clk);
    model_step(pkt, rdy);
    #1;
    check_all(tag);
    bus.stream_in  = '0;
    bus.dout_ready = '0;
  endtask

  initial begin
    logic [PW-1:0] pl;
    reset_n        = 1'b0;
    bus.stream_in  = '0;
    bus.dout_ready = '0;
    model_clear();
    #1;
    check_all("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    // 1: single packet to port 2
    cycle("s1", mk(1'b1, 2, PW'(86'hA5)), '0);
    chk("s1_dout0", 128'(bus.dout[PW-1:0]), 128'(86'hA5));
    chk("s1_valid", 128'(bus.dout_valid), 128'(7'b0000001));
    cycle("s1_drain", '0, '1);

    // 2: packets that must be ignored
    cycle("s2_p0", mk(1'b1, 0, rnd_pl()), '0);
    cycle("s2_p1", mk(1'b1, 1, rnd_pl()), '0);
    cycle("s2_p9", mk(1'b1, 9, rnd_pl()), '0);
    cycle("s2_p15", mk(1'b1, 15, rnd_pl()), '0);
    cycle("s2_nv", mk(1'b0, 3, rnd_pl()), '0);
    chk("s2_valid", 128'(bus.dout_valid), 128'(0));

    // 3: overfill port 5, then drain in order
    for (int k = 1; k <= 5; k++) cycle("s3_fill", mk(1'b1, 5, PW'(k)), '0);
    chk("s3_ovf3", 128'(bus.overflow[3]), 128'(1));
    for (int k = 1; k <= 4; k++) begin
      chk("s3_order", 128'(bus.dout[3*PW +: PW]), 128'(k));
      cycle("s3_drain", '0, 7'b0001000);
    end

    // 4: push into full port 8 while popping
    for (int k = 0; k < 4; k++) cycle("s4_fill", mk(1'b1, 8, PW'(16 + k)), '0);
    cycle("s4_pp", mk(1'b1, 8, PW'(20)), 7'b1000000);
    chk("s4_ovf6", 128'(bus.overflow[6]), 128'(0));
    for (int k = 1; k <= 4; k++) begin
      chk("s4_order", 128'(bus.dout[6*PW +: PW]), 128'(16 + k));
      cycle("s4_drain", '0, 7'b1000000);
    end

    // 5: back-to-back alternating ports with ready held high
    for (int k = 0; k < 12; k++) cycle("s5", mk(1'b1, 2 + (k % 2), rnd_pl()), '1);
    cycle("s5_tail", '0, '1);

    // 6: reset mid-stream
    for (int k = 0; k < 3; k++) cycle("s6_load", mk(1'b1, 2 + k, rnd_pl()), '0);
    #2;
    reset_n = 1'b0;
    model_clear();
    #1;
    check_all("s6_rst");
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    pl = rnd_pl();
    cycle("s6_after", mk(1'b1, 4, pl), '0);
    chk("s6_valid", 128'(bus.dout_valid), 128'(7'b0000100));
    chk("s6_dout2", 128'(bus.dout[2*PW +: PW]), 128'(pl));
    cycle("s6_drain", '0, '1);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      logic vld;
      vld = ($urandom_range(0, 3) != 0);
      cycle("rand", mk(vld, $urandom_range(0, 15), rnd_pl()), NP'($urandom()));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
